// File: rtl/hashmap_upsert.sv
// Upsert sequencer in front of the hashmap: lookup, then modify on hit or queue an insert on miss.
// Same-key hazards stall acceptance so a key is never inserted twice.
module hashmap_upsert #(
  parameter int NUM_KEY_BITS   = 32,
  parameter int NUM_VAL_BITS   = 32,
  parameter int NUM_PIPES      = 2,
  parameter int INS_FIFO_DEPTH = 4,
  parameter bit SATURATE       = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_KEY_BITS-1:0] in_key,
  input  logic [NUM_VAL_BITS-1:0] in_delta,
  input  logic                    in_del,
  output logic                    hm_lookup,
  output logic [NUM_KEY_BITS-1:0] hm_key,
  output logic                    hm_modify,
  output logic                    hm_del,
  output logic [NUM_VAL_BITS-1:0] hm_mod_value,
  input  logic                    hm_valid,
  input  logic [NUM_VAL_BITS-1:0] hm_value,
  output logic                    hm_insert,
  input  logic                    hm_busy,
  output logic [NUM_KEY_BITS-1:0] hm_ins_key,
  output logic [NUM_VAL_BITS-1:0] hm_ins_value,
  output logic                    res_valid,
  output logic [NUM_KEY_BITS-1:0] res_key,
  output logic [NUM_VAL_BITS-1:0] res_value,
  output logic                    res_found,
  output logic                    idle
);

  localparam int K  = NUM_KEY_BITS;
  localparam int V  = NUM_VAL_BITS;
  localparam int P  = NUM_PIPES;
  localparam int D  = INS_FIFO_DEPTH;
  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(P + D + 1);

  logic [P-1:0]  sv_q;
  logic [K-1:0]  sk_q [P];
  logic [V-1:0]  sd_q [P];
  logic [P-1:0]  sdel_q;

  logic [K-1:0]  fk_q [D];
  logic [V-1:0]  fv_q [D];
  logic [D-1:0]  fvld_q;
  logic [PW-1:0] rd_q, wr_q, rd_d, wr_d;
  logic [CW-1:0] fcnt_q, fcnt_d;

  logic          res_valid_q, res_found_q;
  logic [K-1:0]  res_key_q;
  logic [V-1:0]  res_value_q, res_value_d;

  logic [CW-1:0] infl;
  logic          hit, accept;
  logic          r_v, r_del;
  logic [K-1:0]  r_key;
  logic [V-1:0]  r_delta, sum;
  logic [V:0]    sum_ext;
  logic          push, store, pop, fifo_empty;

  // Hazard check covers every in-flight stage (including the one resolving now)
  // and every queued insert (including the one popping now).
  always_comb begin
    infl = '0;
    hit  = 1'b0;
    for (int i = 0; i < P; i++) begin
      infl = infl + CW'(sv_q[i]);
      if (sv_q[i] && (sk_q[i] == in_key)) hit = 1'b1;
    end
    for (int j = 0; j < D; j++) begin
      if (fvld_q[j] && (fk_q[j] == in_key)) hit = 1'b1;
    end
  end

  assign in_ready  = !rst && ((infl + fcnt_q) < CW'(D)) && !hit;
  assign accept    = in_valid && in_ready;
  assign hm_lookup = accept;
  assign hm_key    = in_key;

  always_ff @(posedge clk) begin
    if (rst) begin
      sv_q   <= '0;
      sdel_q <= '0;
      for (int i = 0; i < P; i++) begin
        sk_q[i] <= '0;
        sd_q[i] <= '0;
      end
    end else begin
      sv_q[0]   <= accept;
      sk_q[0]   <= in_key;
      sd_q[0]   <= in_delta;
      sdel_q[0] <= in_del;
      for (int i = 1; i < P; i++) begin
        sv_q[i]   <= sv_q[i-1];
        sk_q[i]   <= sk_q[i-1];
        sd_q[i]   <= sd_q[i-1];
        sdel_q[i] <= sdel_q[i-1];
      end
    end
  end

  assign r_v     = sv_q[P-1];
  assign r_key   = sk_q[P-1];
  assign r_delta = sd_q[P-1];
  assign r_del   = sdel_q[P-1];

  assign sum_ext = {1'b0, hm_value} + {1'b0, r_delta};
  assign sum     = (SATURATE && sum_ext[V]) ? {V{1'b1}} : sum_ext[V-1:0];

  assign hm_modify    = !rst && r_v && hm_valid;
  assign hm_del       = hm_modify && r_del;
  assign hm_mod_value = sum;

  // A miss arriving at an empty, non-busy FIFO bypasses storage and inserts this cycle.
  assign push       = !rst && r_v && !hm_valid && !r_del;
  assign fifo_empty = (fcnt_q == '0);
  assign hm_insert  = !rst && (!fifo_empty || push) && !hm_busy;
  assign hm_ins_key   = fifo_empty ? r_key   : fk_q[rd_q];
  assign hm_ins_value = fifo_empty ? r_delta : fv_q[rd_q];
  assign pop        = hm_insert && !fifo_empty;
  assign store      = push && !(fifo_empty && !hm_busy);

  always_comb begin
    wr_d   = store ? ((wr_q == PW'(D - 1)) ? '0 : wr_q + PW'(1)) : wr_q;
    rd_d   = pop   ? ((rd_q == PW'(D - 1)) ? '0 : rd_q + PW'(1)) : rd_q;
    fcnt_d = fcnt_q + CW'(store) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fvld_q <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      fcnt_q <= '0;
      for (int j = 0; j < D; j++) begin
        fk_q[j] <= '0;
        fv_q[j] <= '0;
      end
    end else begin
      if (store) begin
        fk_q[wr_q]   <= r_key;
        fv_q[wr_q]   <= r_delta;
        fvld_q[wr_q] <= 1'b1;
      end
      if (pop) fvld_q[rd_q] <= 1'b0;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      fcnt_q <= fcnt_d;
    end
  end

  always_comb begin
    res_value_d = '0;
    if (hm_valid) res_value_d = r_del ? hm_value : sum;
    else          res_value_d = r_del ? '0 : r_delta;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_found_q <= 1'b0;
      res_key_q   <= '0;
      res_value_q <= '0;
    end else begin
      res_valid_q <= r_v;
      if (r_v) begin
        res_found_q <= hm_valid;
        res_key_q   <= r_key;
        res_value_q <= res_value_d;
      end
    end
  end

  assign res_valid = res_valid_q;
  assign res_found = res_found_q;
  assign res_key   = res_key_q;
  assign res_value = res_value_q;
  assign idle      = (infl == '0) && fifo_empty;

endmodule
